// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 fetch types and constants
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W          = 32;
  localparam int unsigned PC_INCR          = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {pc, instr} holding buffer for decode stalls
module fetch_hold_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch stage with stall hold buffer and branch squash
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles,
`endif
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid
);

  localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  disc_addr_q, disc_addr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               buf_load, buf_clear, buf_valid;
  logic [ADDR_W-1:0]  buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic               ifid_loaded;
  logic [ADDR_W-1:0]  target_aligned;

  assign target_aligned = branch_target & ~ADDR_W'(3);

  fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold_buf (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .instr_o (buf_instr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      disc_addr_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      disc_addr_q  <= disc_addr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    disc_addr_d  = disc_addr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    ifid_loaded  = 1'b0;
    if (branch_taken) begin
      pc_d = target_aligned;
      if (state_q != DISCARD) begin
        ifid_valid_d = 1'b0;
        buf_clear    = 1'b1;
        // An outstanding request must be drained before the target is fetched.
        if (state_q == FETCH && !imem_ready) begin
          state_d     = DISCARD;
          disc_addr_d = pc_q;
        end else begin
          state_d = FETCH;
        end
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + INCR;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata;
              ifid_valid_d = 1'b1;
              ifid_loaded  = 1'b1;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_pc_d    = buf_pc;
            ifid_instr_d = buf_instr;
            ifid_valid_d = buf_valid;
            ifid_loaded  = buf_valid;
            buf_clear    = 1'b1;
            state_d      = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  assign imem_req   = reset && (state_q != HOLD);
  assign imem_addr  = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (ifid_loaded) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall)       perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  logic unused_loaded;
  assign unused_loaded = ifid_loaded;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ADDR_W(64), .RESET_PC(64'h100)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef FETCH_PERF_EN
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        br;
    logic [63:0] tgt;
    logic [31:0] rd;
    logic        req;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rdy, input logic br, input logic [63:0] tgt,
                     input logic [31:0] rd, input logic req, input logic [63:0] addr,
                     input logic v, input logic [63:0] pc, input logic [31:0] ins);
    vec_t t;
    t.st = st; t.rdy = rdy; t.br = br; t.tgt = tgt; t.rd = rd;
    t.req = req; t.addr = addr; t.v = v; t.pc = pc; t.ins = ins;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // stall, ready, branch, target, rdata | req, addr | valid, ifid_pc, ifid_instr
    add(0,1,0,64'h0,   32'h11111111, 1,64'h100, 1,64'h100,32'h11111111);
    add(0,1,0,64'h0,   32'h22222222, 1,64'h104, 1,64'h104,32'h22222222);
    add(0,1,0,64'h0,   32'h33333333, 1,64'h108, 1,64'h108,32'h33333333);
    add(0,0,0,64'h0,   32'hDEADDEAD, 1,64'h10C, 0,64'h108,32'h33333333);
    add(0,0,0,64'h0,   32'hDEADDEAD, 1,64'h10C, 0,64'h108,32'h33333333);
    add(0,1,0,64'h0,   32'h44444444, 1,64'h10C, 1,64'h10C,32'h44444444);
    add(0,1,0,64'h0,   32'h55555555, 1,64'h110, 1,64'h110,32'h55555555);
    add(1,1,0,64'h0,   32'h66666666, 1,64'h114, 1,64'h110,32'h55555555);
    add(1,1,0,64'h0,   32'h77777777, 0,64'h118, 1,64'h110,32'h55555555);
    add(1,0,0,64'h0,   32'h77777777, 0,64'h118, 1,64'h110,32'h55555555);
    add(0,0,0,64'h0,   32'h77777777, 0,64'h118, 1,64'h114,32'h66666666);
    add(0,1,0,64'h0,   32'h88888888, 1,64'h118, 1,64'h118,32'h88888888);
    add(0,0,1,64'h203, 32'hDEADDEAD, 1,64'h11C, 0,64'h118,32'h88888888);
    add(0,0,0,64'h0,   32'hDEADDEAD, 1,64'h11C, 0,64'h118,32'h88888888);
    add(0,1,0,64'h0,   32'h99999999, 1,64'h11C, 0,64'h118,32'h88888888);
    add(0,1,0,64'h0,   32'hAAAAAAAA, 1,64'h200, 1,64'h200,32'hAAAAAAAA);
    add(1,1,1,64'h300, 32'hBBBBBBBB, 1,64'h204, 0,64'h200,32'hAAAAAAAA);
    add(0,1,0,64'h0,   32'hCCCCCCCC, 1,64'h300, 1,64'h300,32'hCCCCCCCC);
    add(1,1,0,64'h0,   32'hDDDDDDDD, 1,64'h304, 1,64'h300,32'hCCCCCCCC);
    add(1,0,1,64'h400, 32'hDEADDEAD, 0,64'h308, 0,64'h300,32'hCCCCCCCC);
    add(0,1,0,64'h0,   32'hEEEEEEEE, 1,64'h400, 1,64'h400,32'hEEEEEEEE);
    add(0,0,1,64'h500, 32'hDEADDEAD, 1,64'h404, 0,64'h400,32'hEEEEEEEE);
    add(0,0,1,64'h600, 32'hDEADDEAD, 1,64'h404, 0,64'h400,32'hEEEEEEEE);
    add(0,1,0,64'h0,   32'h5A5A5A5A, 1,64'h404, 0,64'h400,32'hEEEEEEEE);
    add(0,1,0,64'h0,   32'hF0F0F0F0, 1,64'h600, 1,64'h600,32'hF0F0F0F0);
    add(0,1,1,64'hFFFF_FFFF_FFFF_FFFE, 32'hDEADDEAD, 1,64'h604, 0,64'h600,32'hF0F0F0F0);
    add(0,1,0,64'h0,   32'h12345678, 1,64'hFFFF_FFFF_FFFF_FFFC, 1,64'hFFFF_FFFF_FFFF_FFFC,32'h12345678);
    add(0,1,0,64'h0,   32'h87654321, 1,64'h0,   1,64'h0,  32'h87654321);
    add(1,1,0,64'h0,   32'hCAFEF00D, 1,64'h4,   1,64'h0,  32'h87654321);

    reset = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    #12;
    chk("rst_req",   -1, 64'(imem_req),   64'h0);
    chk("rst_addr",  -1, imem_addr,       64'h100);
    chk("rst_valid", -1, 64'(ifid_valid), 64'h0);
    chk("rst_pc",    -1, ifid_pc,         64'h0);
    chk("rst_instr", -1, 64'(ifid_instr), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].st; imem_ready = vecs[i].rdy; branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt; imem_rdata = vecs[i].rd;
      #1;
      chk("imem_req",  i, 64'(imem_req), 64'(vecs[i].req));
      chk("imem_addr", i, imem_addr,     vecs[i].addr);
      @(posedge clk); #1;
      chk("ifid_valid", i, 64'(ifid_valid), 64'(vecs[i].v));
      chk("ifid_pc",    i, ifid_pc,         vecs[i].pc);
      chk("ifid_instr", i, 64'(ifid_instr), 64'(vecs[i].ins));
      @(negedge clk);
    end

    // Last vector left the stage in HOLD; reset must clear it without a clock edge.
    #1;
    chk("hold_req", 0, 64'(imem_req), 64'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req",   0, 64'(imem_req),   64'h0);
    chk("mid_rst_addr",  0, imem_addr,       64'h100);
    chk("mid_rst_valid", 0, 64'(ifid_valid), 64'h0);
    chk("mid_rst_pc",    0, ifid_pc,         64'h0);
    chk("mid_rst_instr", 0, 64'(ifid_instr), 64'h0);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0;
    imem_rdata = 32'h0BADCAFE;
    #1;
    chk("post_rst_req",  0, 64'(imem_req), 64'h1);
    chk("post_rst_addr", 0, imem_addr,     64'h100);
    @(posedge clk); #1;
    chk("post_rst_valid", 0, 64'(ifid_valid), 64'h1);
    chk("post_rst_pc",    0, ifid_pc,         64'h100);
    chk("post_rst_instr", 0, 64'(ifid_instr), 64'h0BADCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the pipelined LEGv8 CPU, sitting directly upstream of decode/control and the register bank. It owns the program counter, issues requests to instruction memory over a ready-based handshake, and presents {pc, instruction, valid} in the IF/ID pipeline register. It also honours decode-stage stalls through a one-entry hold buffer and branch redirects with squash.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset
- ADDR_W, 64, PC/address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address; stable while imem_req high and imem_ready low
- imem_ready  in  1  response valid this cycle (qualifies imem_rdata)
- imem_rdata  in  32  fetched instruction
- stall  in  1  decode cannot accept; IF/ID must hold
- branch_taken  in  1  redirect request (already qualified zero & Branch)
- branch_target  in  ADDR_W  redirect address
- ifid_pc  out  ADDR_W  PC of instruction in IF/ID
- ifid_instr  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a live instruction

## Operation
- States: FETCH, HOLD, DISCARD. Reset state FETCH.
- Reset values: pc=RESET_PC, ifid_pc=0, ifid_instr=0, ifid_valid=0, hold buffer empty, imem_req=0 while reset asserted.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready & !stall: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4.
  - imem_ready & stall: buffer <= {pc, imem_rdata}; pc <= pc+4; go HOLD; IF/ID unchanged.
  - !imem_ready & !stall: ifid_valid <= 0 (bubble). !imem_ready & stall: IF/ID unchanged.
- HOLD: imem_req=0. When stall drops: IF/ID <= buffer with valid=1; go FETCH.
- DISCARD: imem_req=1 with the abandoned address still on imem_addr; on imem_ready the response is dropped and the state goes to FETCH (pc already holds the target).
- Redirect (branch_taken) has priority over everything, including stall:
  - pc <= {branch_target[ADDR_W-1:2], 2'b00};
  - ifid_valid <= 0; buffer cleared.
  - Next state is DISCARD if in FETCH with imem_ready=0, otherwise FETCH.
- Redirect while in DISCARD updates pc only and stays in DISCARD.
- PC arithmetic is unsigned modulo 2^ADDR_W; pc+4 wraps from all-ones-minus-3 to 0.

## Timing
- Zero-wait memory (imem_ready tied high): one instruction per cycle; IF/ID updates on the edge closing the ready cycle.
- First request: imem_req rises in the first cycle after reset deasserts, with imem_addr=RESET_PC.
- Redirect penalty: target fetch is issued the cycle after branch_taken (zero-wait memory); instructions in flight are squashed.
- HOLD release: the buffered instruction appears in IF/ID on the edge after stall falls. The next fetch is issued in the following cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); no partial IF/ID update.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32-bit, increments on each instruction loaded into IF/ID with valid=1) and perf_stall_cycles (32-bit, increments each cycle stall=1). Both reset to 0 and wrap at 2^32.
- FETCH_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg: fetch state enum (FETCH/HOLD/DISCARD), INSTR_W=32, PC_INCR=4, RESET_PC default.
- One sub-module: fetch_hold_buf, a one-entry {pc, instr} buffer with load/clear/valid.

## Test plan
- Reset with RESET_PC=0x100, ready tied high, no stall -> IF/ID pcs 0x100, 0x104, 0x108 on consecutive cycles, valid=1.
- Ready pattern 0,0,1 -> imem_addr stable at 0x100 for 3 cycles; ifid_valid=0 for two cycles, then {0x100, rdata}.
- Stall high for 3 cycles in the same cycle ready returns 0x104 -> IF/ID holds 0x100 entry; imem_req=0 in HOLD; 0x104 enters IF/ID the edge after stall falls.
- branch_taken with target 0x203 while ready=0 -> DISCARD; late response dropped; next IF/ID pc=0x200.
- branch_taken and stall in the same cycle -> ifid_valid=0 next cycle; fetch resumes at the target.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0. Asserting reset mid-HOLD -> all outputs return to reset values immediately.
